// File: rtl/stats_uart_tx.sv
// Purpose: UART 8N1 telemetry transmitter that sends a fixed packet: header, five 5-bit stats, sleep flag.
// Latency: uart_tx falls one cycle after send is accepted; done comes 1 + N*10*CLKS_PER_BIT cycles after it.
// Backpressure: send is taken only while idle; requests while busy or on the done cycle are dropped, not queued.
// Optional feature: define STATS_TX_CHECKSUM_EN to append an XOR checksum byte of the payload (N=8, else N=7).
module stats_uart_tx #(
  parameter int         CLKS_PER_BIT = 87,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [4:0] hunger,
  input  logic [4:0] happiness,
  input  logic [4:0] health,
  input  logic [4:0] hygiene,
  input  logic [4:0] energy,
  input  logic       is_sleeping,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef STATS_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd7;
`else
  localparam logic [2:0] LAST_BYTE = 3'd6;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       byte_idx;

  logic [4:0] snap_hunger;
  logic [4:0] snap_happiness;
  logic [4:0] snap_health;
  logic [4:0] snap_hygiene;
  logic [4:0] snap_energy;
  logic       snap_sleeping;

  logic [7:0] cur_byte;

  // Select the packet byte currently being shifted out from the snapshot.
  always_comb begin
    cur_byte = 8'hFF;
    case (byte_idx)
      3'd0: cur_byte = HEADER;
      3'd1: cur_byte = {3'b000, snap_hunger};
      3'd2: cur_byte = {3'b000, snap_happiness};
      3'd3: cur_byte = {3'b000, snap_health};
      3'd4: cur_byte = {3'b000, snap_hygiene};
      3'd5: cur_byte = {3'b000, snap_energy};
      3'd6: cur_byte = {7'b0000000, snap_sleeping};
`ifdef STATS_TX_CHECKSUM_EN
      3'd7: cur_byte = {3'b000, snap_hunger ^ snap_happiness ^ snap_health ^
                                snap_hygiene ^ snap_energy} ^
                       {7'b0000000, snap_sleeping};
`endif
      default: cur_byte = 8'hFF;
    endcase
  end

  // Frame sequencer. uart_tx is registered from the current state, so the line
  // trails the state by one cycle; done/busy are closed out in the first IDLE
  // cycle so they line up with the end of the final stop bit on the wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      bit_idx        <= '0;
      byte_idx       <= '0;
      uart_tx        <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      snap_hunger    <= '0;
      snap_happiness <= '0;
      snap_health    <= '0;
      snap_hygiene   <= '0;
      snap_energy    <= '0;
      snap_sleeping  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (busy) begin
            // Packet just finished on the wire; send is ignored this cycle.
            busy <= 1'b0;
            done <= 1'b1;
          end else if (send) begin
            snap_hunger    <= hunger;
            snap_happiness <= happiness;
            snap_health    <= health;
            snap_hygiene   <= hygiene;
            snap_energy    <= energy;
            snap_sleeping  <= is_sleeping;
            byte_idx       <= '0;
            bit_idx        <= '0;
            bit_cnt        <= '0;
            busy           <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          uart_tx <= 1'b0;
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          uart_tx <= cur_byte[bit_idx];
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= START;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stats_uart_tx.sv
// Bench for stats_uart_tx with CLKS_PER_BIT=4: table vectors, random packets
// against a bit-timing model, plus hand sequences for the multi-cycle corners.
module tb_stats_uart_tx;

  localparam int C = 4;
`ifdef STATS_TX_CHECKSUM_EN
  localparam int N = 8;
`else
  localparam int N = 7;
`endif
  localparam int TOT = N * 10 * C;   // packet length on the wire
  localparam int P   = TOT + 2;      // accept-to-accept period with send held

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [4:0] hunger = '0, happiness = '0, health = '0, hygiene = '0, energy = '0;
  logic       is_sleeping = 1'b0;
  logic       uart_tx, busy, done;

  stats_uart_tx #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (
    .clk(clk), .reset(reset), .send(send),
    .hunger(hunger), .happiness(happiness), .health(health),
    .hygiene(hygiene), .energy(energy), .is_sleeping(is_sleeping),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_b [8];
  logic [7:0] dec   [8];
  logic       samp  [P];

  typedef struct {
    logic [4:0]  hu, ha, he, hy, en;
    logic        sl;
    logic [63:0] exp;   // byte 0 in the top 8 bits, checksum in the bottom 8
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet contents straight from the byte-layout rules.
  function automatic logic [7:0] pkt_byte(input int i);
    case (i)
      0: return 8'hA5;
      1: return {3'b0, hunger};
      2: return {3'b0, happiness};
      3: return {3'b0, health};
      4: return {3'b0, hygiene};
      5: return {3'b0, energy};
      6: return {7'b0, is_sleeping};
      default: return {3'b0, hunger ^ happiness ^ health ^ hygiene ^ energy} ^ {7'b0, is_sleeping};
    endcase
  endfunction

  task automatic set_expected();
    for (int i = 0; i < 8; i++) exp_b[i] = pkt_byte(i);
  endtask

  // Line level t cycles into a packet: 10 bit slots per byte, C cycles each.
  function automatic logic model_tx(input int t);
    int by, pos;
    by  = t / (10 * C);
    pos = (t % (10 * C)) / C;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return exp_b[by][pos-1];
  endfunction

  function automatic logic samp_at(input int i);
    if (i < 0 || i >= P) return 1'b1;
    return samp[i];
  endfunction

  // mode 0: plain; 1: stats zeroed and send pulsed mid-packet; 2: send high on the done edge
  task automatic run_packet(input string tag, input int mode);
    int tx_bad, busy_bad, done_bad, done_at, s, base, frame_bad;
    logic etx;
    tx_bad = 0; busy_bad = 0; done_bad = 0; done_at = -1; frame_bad = 0;
    set_expected();
    send = 1'b1;
    @(posedge clk);
    for (int k = 0; k < P; k++) begin
      @(negedge clk);
      samp[k] = uart_tx;
      etx = (k >= 1 && k <= TOT) ? model_tx(k - 1) : 1'b1;
      if (uart_tx !== etx) tx_bad++;
      if (busy !== (k <= TOT)) busy_bad++;
      if (done !== (k == TOT + 1)) done_bad++;
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (k == 0) send = 1'b0;
      if (mode == 1 && k == 5) begin
        hunger = 0; happiness = 0; health = 0; hygiene = 0; energy = 0; is_sleeping = 0;
      end
      if (mode == 1 && k == 50) send = 1'b1;
      if (mode == 1 && k == 51) send = 1'b0;
      if (mode == 2 && k == TOT) send = 1'b1;
      if (mode == 2 && k == TOT + 1) send = 1'b0;
    end
    check({tag, " tx waveform bad cycles"}, tx_bad, 0);
    check({tag, " busy bad cycles"}, busy_bad, 0);
    check({tag, " done bad cycles"}, done_bad, 0);
    check({tag, " done latency"}, done_at, TOT + 1);
    // Mid-bit UART decode of the captured line.
    s = 0;
    while (s < P && samp[s] !== 1'b0) s++;
    for (int i = 0; i < 8; i++) dec[i] = 8'h00;
    for (int i = 0; i < N; i++) begin
      base = s + i * 10 * C;
      if (samp_at(base + C / 2) !== 1'b0 || samp_at(base + 9 * C + C / 2) !== 1'b1) frame_bad++;
      for (int j = 0; j < 8; j++) dec[i][j] = samp_at(base + (j + 1) * C + C / 2);
    end
    check({tag, " framing errors"}, frame_bad, 0);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check({tag, " idle bad cycles"}, bad, 0);
  endtask

  task automatic set_inputs(input vec_t v);
    hunger = v.hu; happiness = v.ha; health = v.he; hygiene = v.hy; energy = v.en; is_sleeping = v.sl;
  endtask

  initial begin
    int bad_tx, bad_busy, bad_done;
    logic etx;
    int o;
    vec_t rv;

    tbl[0] = '{5'd17, 5'd31, 5'd0,  5'd8,  5'd3,  1'b1, 64'hA5_11_1F_00_08_03_01_04};
    tbl[1] = '{5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 64'hA5_00_00_00_00_00_00_00};
    tbl[2] = '{5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 1'b1, 64'hA5_1F_1F_1F_1F_1F_01_1E};
    tbl[3] = '{5'd21, 5'd10, 5'd5,  5'd26, 5'd1,  1'b0, 64'hA5_15_0A_05_1A_01_00_01};

    // Reset state, then 20 idle cycles after release
    repeat (3) @(negedge clk);
    check("reset tx", uart_tx, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    reset = 1'b0;
    expect_quiet("post-reset", 20);

    // Table vectors: decoded bytes against hand-derived constants
    for (int v = 0; v < 4; v++) begin
      set_inputs(tbl[v]);
      run_packet($sformatf("tbl%0d", v), 0);
      for (int i = 0; i < N; i++)
        check($sformatf("tbl%0d byte%0d", v, i), dec[i], tbl[v].exp[63 - 8*i -: 8]);
      repeat (2) @(negedge clk);
    end

    // Random stats against the model
    for (int r = 0; r < 5; r++) begin
      rv = '{5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
             5'($urandom_range(31)), 5'($urandom_range(31)), 1'($urandom_range(1)), 64'h0};
      set_inputs(rv);
      run_packet($sformatf("rnd%0d", r), 0);
      for (int i = 0; i < N; i++)
        check($sformatf("rnd%0d byte%0d", r, i), dec[i], exp_b[i]);
      @(negedge clk);
    end

    // Snapshot holds while inputs change; send during busy is dropped
    set_inputs(tbl[0]);
    run_packet("snapshot", 1);
    for (int i = 0; i < N; i++)
      check($sformatf("snapshot byte%0d", i), dec[i], tbl[0].exp[63 - 8*i -: 8]);
    expect_quiet("snapshot", 40);

    // send high only on the done edge is ignored
    set_inputs(tbl[3]);
    run_packet("done-edge", 2);
    expect_quiet("done-edge", 40);

    // Reset in data bit 3 of byte 2, then a clean packet with energy=31
    set_inputs(tbl[0]);
    set_expected();
    send = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 98; k++) begin
      @(negedge clk);
      if (k == 0) send = 1'b0;
    end
    check("pre-abort tx data bit", uart_tx, model_tx(97));
    check("pre-abort busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("abort tx", uart_tx, 1'b1);
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    expect_quiet("post-abort", 5);
    energy = 5'd31;
    run_packet("after-abort", 0);
    check("after-abort byte5", dec[5], 8'h1F);
    for (int i = 0; i < N; i++)
      check($sformatf("after-abort byte%0d", i), dec[i], exp_b[i]);
    @(negedge clk);

    // send held high: back-to-back packets, period TOT+2
    rv = '{5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
           5'($urandom_range(31)), 5'($urandom_range(31)), 1'($urandom_range(1)), 64'h0};
    set_inputs(rv);
    set_expected();
    bad_tx = 0; bad_busy = 0; bad_done = 0;
    send = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      o = k % P;
      etx = (o >= 1 && o <= TOT) ? model_tx(o - 1) : 1'b1;
      if (uart_tx !== etx) bad_tx++;
      if (busy !== (o <= TOT)) bad_busy++;
      if (done !== (o == TOT + 1)) bad_done++;
    end
    send = 1'b0;
    check("held tx bad cycles", bad_tx, 0);
    check("held busy bad cycles", bad_busy, 0);
    check("held done bad cycles", bad_done, 0);
    o = 0;
    while (busy === 1'b1 && o < TOT + 10) begin
      @(negedge clk);
      o++;
    end
    check("held drain busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
